// File: rtl/pc_ras_gen.sv
// rtl/pc_ras_gen.sv - fetch-stage next-PC generator with pending redirect buffer and return-address stack
module pc_ras_gen #(
   parameter int                XLEN       = 32,
   parameter logic [XLEN-1:0]   RESET_PC   = 32'h0000_0000,
   parameter int                INST_BYTES = 4,
   parameter int                RAS_DEPTH  = 4
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            keep_i,
   input  logic            trap_i,
   input  logic [XLEN-1:0] trap_pc_i,
   input  logic            back_i,
   input  logic [XLEN-1:0] npc_i,
   input  logic            call_i,
   input  logic [XLEN-1:0] ret_addr_i,
   input  logic            ret_i,
   output logic [XLEN-1:0] pc_o,
   output logic [XLEN-1:0] pc4_o,
   output logic            valid_o,
   output logic            redirect_o,
   output logic            ras_empty_o,
   output logic            ras_full_o
);

   localparam int PW = $clog2(RAS_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {P_NONE, P_TRAP, P_BACK} pend_e;

   logic [XLEN-1:0] pc_q;
   logic            valid_q, redirect_q;
   pend_e           pend_q;
   logic [XLEN-1:0] pend_pc_q;
   logic [XLEN-1:0] ras_mem [RAS_DEPTH];
   logic [PW-1:0]   ptr_q, top_idx;
   logic [CW-1:0]   cnt_q;

   logic [XLEN-1:0] next_pc, top_val;
   logic            redir_n, trap_taken, flow_taken;
   logic            do_push, do_pop, do_replace, ras_nonempty;

   assign top_idx      = ptr_q - 1'b1;
   assign top_val      = ras_mem[top_idx];
   assign ras_nonempty = (cnt_q != '0);

   always_comb begin
      next_pc    = pc_q + XLEN'(INST_BYTES);
      redir_n    = 1'b0;
      trap_taken = 1'b0;
      flow_taken = 1'b0;
      do_push    = 1'b0;
      do_pop     = 1'b0;
      do_replace = 1'b0;
      if (pend_q == P_TRAP) begin
         next_pc    = pend_pc_q;
         trap_taken = 1'b1;
      end else if (trap_i) begin
         next_pc    = trap_pc_i;
         trap_taken = 1'b1;
      end else if (pend_q == P_BACK) begin
         next_pc    = pend_pc_q;
         flow_taken = 1'b1;
      end else if (back_i) begin
         next_pc    = npc_i;
         flow_taken = 1'b1;
      end else if (call_i && ret_i) begin
         // Call-and-return in one instruction swaps the top entry rather than pop+push.
         if (ras_nonempty) begin
            next_pc    = top_val;
            redir_n    = 1'b1;
            do_replace = 1'b1;
         end else begin
            do_push = 1'b1;
         end
      end else if (call_i) begin
         do_push = 1'b1;
      end else if (ret_i && ras_nonempty) begin
         next_pc = top_val;
         redir_n = 1'b1;
         do_pop  = 1'b1;
      end
      if (trap_taken || flow_taken) redir_n = 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pc_q       <= RESET_PC - XLEN'(INST_BYTES);
         valid_q    <= 1'b0;
         redirect_q <= 1'b0;
         pend_q     <= P_NONE;
         pend_pc_q  <= '0;
         ptr_q      <= '0;
         cnt_q      <= '0;
      end else if (keep_i) begin
         redirect_q <= 1'b0;
         if (trap_i) begin
            pend_q    <= P_TRAP;
            pend_pc_q <= trap_pc_i;
         end else if (back_i && pend_q != P_TRAP) begin
            pend_q    <= P_BACK;
            pend_pc_q <= npc_i;
         end
      end else begin
         pc_q       <= next_pc;
         valid_q    <= 1'b1;
         redirect_q <= redir_n;
         // Any advance consumes or supersedes whatever was pending.
         pend_q     <= P_NONE;
         if (trap_taken) begin
            ptr_q <= '0;
            cnt_q <= '0;
         end else if (do_push) begin
            ptr_q <= ptr_q + 1'b1;
            if (cnt_q != CW'(RAS_DEPTH)) cnt_q <= cnt_q + 1'b1;
         end else if (do_pop) begin
            ptr_q <= top_idx;
            cnt_q <= cnt_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i && !keep_i) begin
         if (do_push)         ras_mem[ptr_q]   <= ret_addr_i;
         else if (do_replace) ras_mem[top_idx] <= ret_addr_i;
      end
   end

   assign pc_o        = pc_q;
   assign pc4_o       = pc_q + XLEN'(INST_BYTES);
   assign valid_o     = valid_q;
   assign redirect_o  = redirect_q;
   assign ras_empty_o = (cnt_q == '0);
   assign ras_full_o  = (cnt_q == CW'(RAS_DEPTH));

endmodule

// File: tb/tb_pc_ras_gen.sv
// tb/tb_pc_ras_gen.sv - directed self-checking bench for pc_ras_gen
module tb_pc_ras_gen;

   logic        clk = 1'b0;
   logic        rst, keep, trap, back, call, ret;
   logic [31:0] trap_pc, npc, ret_addr;
   logic [31:0] pc, pc4;
   logic        valid, redirect, ras_empty, ras_full;
   int          total = 0;
   int          passed = 0;

   always #5 clk = ~clk;

   pc_ras_gen dut (
      .clk_i(clk), .rst_i(rst), .keep_i(keep), .trap_i(trap), .trap_pc_i(trap_pc),
      .back_i(back), .npc_i(npc), .call_i(call), .ret_addr_i(ret_addr), .ret_i(ret),
      .pc_o(pc), .pc4_o(pc4), .valid_o(valid), .redirect_o(redirect),
      .ras_empty_o(ras_empty), .ras_full_o(ras_full)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      keep = 0; trap = 0; back = 0; call = 0; ret = 0;
      trap_pc = 0; npc = 0; ret_addr = 0;
   endtask

   task automatic test_reset();
      idle(); rst = 1;
      tick(); tick();
      total++; if (pc !== 32'hFFFF_FFFC) $display("FAIL reset_pc got %h exp %h", pc, 32'hFFFF_FFFC); else passed++;
      total++; if (valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", valid); else passed++;
      total++; if (redirect !== 1'b0) $display("FAIL reset_redirect got %b exp 0", redirect); else passed++;
      total++; if ({ras_empty, ras_full} !== 2'b10) $display("FAIL reset_ras got %b exp 10", {ras_empty, ras_full}); else passed++;
      rst = 0;
      tick();
      total++; if (pc !== 32'h0) $display("FAIL first_pc got %h exp %h", pc, 32'h0); else passed++;
      total++; if (valid !== 1'b1) $display("FAIL first_valid got %b exp 1", valid); else passed++;
      tick();
      total++; if (pc !== 32'h4) $display("FAIL seq_pc4 got %h exp %h", pc, 32'h4); else passed++;
      tick();
      total++; if (pc !== 32'h8) $display("FAIL seq_pc8 got %h exp %h", pc, 32'h8); else passed++;
      total++; if (pc4 !== 32'hC) $display("FAIL pc4_out got %h exp %h", pc4, 32'hC); else passed++;
   endtask

   task automatic test_stall_back();
      keep = 1; back = 1; npc = 32'h100;
      tick();
      back = 0;
      total++; if (pc !== 32'h8) $display("FAIL stall_hold1 got %h exp %h", pc, 32'h8); else passed++;
      tick(); tick();
      total++; if (pc !== 32'h8) $display("FAIL stall_hold3 got %h exp %h", pc, 32'h8); else passed++;
      total++; if (redirect !== 1'b0) $display("FAIL stall_redirect got %b exp 0", redirect); else passed++;
      keep = 0;
      tick();
      total++; if (pc !== 32'h100) $display("FAIL pend_back_pc got %h exp %h", pc, 32'h100); else passed++;
      total++; if (redirect !== 1'b1) $display("FAIL pend_back_redirect got %b exp 1", redirect); else passed++;
      tick();
      total++; if (pc !== 32'h104) $display("FAIL after_back_pc got %h exp %h", pc, 32'h104); else passed++;
      total++; if (redirect !== 1'b0) $display("FAIL redirect_pulse got %b exp 0", redirect); else passed++;
   endtask

   task automatic test_pending_trap();
      call = 1; ret_addr = 32'h44;
      tick();
      call = 0;
      total++; if (pc !== 32'h108 || ras_empty !== 1'b0) $display("FAIL pre_call pc=%h empty=%b exp 108/0", pc, ras_empty); else passed++;
      keep = 1; back = 1; npc = 32'h200;
      tick();
      back = 0; trap = 1; trap_pc = 32'h80;
      tick();
      trap = 0; back = 1; npc = 32'h300;
      tick();
      keep = 0; back = 0;
      tick();
      total++; if (pc !== 32'h80) $display("FAIL pend_trap_pc got %h exp %h", pc, 32'h80); else passed++;
      total++; if (redirect !== 1'b1) $display("FAIL pend_trap_redirect got %b exp 1", redirect); else passed++;
      total++; if (ras_empty !== 1'b1) $display("FAIL trap_clears_ras got %b exp 1", ras_empty); else passed++;
      tick();
      total++; if (pc !== 32'h84) $display("FAIL after_trap_pc got %h exp %h", pc, 32'h84); else passed++;
   endtask

   task automatic test_ras_fill();
      logic [31:0] pushes [5] = '{32'h10, 32'h20, 32'h30, 32'h40, 32'h50};
      logic [31:0] pops   [4] = '{32'h50, 32'h40, 32'h30, 32'h20};
      call = 1;
      for (int i = 0; i < 5; i++) begin
         ret_addr = pushes[i];
         tick();
         total++; if (pc !== 32'h88 + 32'(4 * i)) $display("FAIL call_seq%0d got %h exp %h", i, pc, 32'h88 + 32'(4 * i)); else passed++;
      end
      call = 0;
      total++; if (ras_full !== 1'b1) $display("FAIL ras_full got %b exp 1", ras_full); else passed++;
      ret = 1;
      for (int i = 0; i < 4; i++) begin
         tick();
         total++; if (pc !== pops[i] || redirect !== 1'b1) $display("FAIL ret%0d pc=%h redir=%b exp %h/1", i, pc, redirect, pops[i]); else passed++;
      end
      total++; if (ras_empty !== 1'b1) $display("FAIL ras_drained got %b exp 1", ras_empty); else passed++;
      tick();
      ret = 0;
      total++; if (pc !== 32'h24 || redirect !== 1'b0) $display("FAIL ret_empty pc=%h redir=%b exp 24/0", pc, redirect); else passed++;
   endtask

   task automatic test_call_ret();
      call = 1; ret_addr = 32'h10;
      tick();
      ret_addr = 32'h20;
      tick();
      total++; if (pc !== 32'h2C) $display("FAIL cr_pre_pc got %h exp %h", pc, 32'h2C); else passed++;
      ret = 1; ret_addr = 32'h99;
      tick();
      call = 0;
      total++; if (pc !== 32'h20 || redirect !== 1'b1) $display("FAIL cr_pc pc=%h redir=%b exp 20/1", pc, redirect); else passed++;
      tick();
      total++; if (pc !== 32'h99) $display("FAIL cr_top_replaced got %h exp %h", pc, 32'h99); else passed++;
      tick();
      ret = 0;
      total++; if (pc !== 32'h10 || ras_empty !== 1'b1) $display("FAIL cr_count pc=%h empty=%b exp 10/1", pc, ras_empty); else passed++;
   endtask

   task automatic test_back_ret();
      call = 1; ret_addr = 32'h55;
      tick();
      call = 0;
      back = 1; ret = 1; npc = 32'h400;
      tick();
      back = 0;
      total++; if (pc !== 32'h400 || redirect !== 1'b1) $display("FAIL back_ret pc=%h redir=%b exp 400/1", pc, redirect); else passed++;
      total++; if (ras_empty !== 1'b0) $display("FAIL back_keeps_ras got %b exp 0", ras_empty); else passed++;
      tick();
      ret = 0;
      total++; if (pc !== 32'h55) $display("FAIL ras_after_back got %h exp %h", pc, 32'h55); else passed++;
   endtask

   task automatic test_wrap_and_reset();
      back = 1; npc = 32'hFFFF_FFF8;
      tick();
      back = 0;
      tick();
      total++; if (pc !== 32'hFFFF_FFFC || pc4 !== 32'h0) $display("FAIL wrap_pre pc=%h pc4=%h exp fffffffc/0", pc, pc4); else passed++;
      tick();
      total++; if (pc !== 32'h0) $display("FAIL wrap_pc got %h exp %h", pc, 32'h0); else passed++;
      keep = 1; back = 1; npc = 32'h700; rst = 1;
      tick();
      total++; if (pc !== 32'hFFFF_FFFC || valid !== 1'b0) $display("FAIL rst_in_stall pc=%h valid=%b exp fffffffc/0", pc, valid); else passed++;
      rst = 0; keep = 0; back = 0;
      tick();
      total++; if (pc !== 32'h0 || redirect !== 1'b0) $display("FAIL rst_clears_pend pc=%h redir=%b exp 0/0", pc, redirect); else passed++;
   endtask

   initial begin
      rst = 1; idle();
      test_reset();
      test_stall_back();
      test_pending_trap();
      test_ras_fill();
      test_call_ret();
      test_back_ret();
      test_wrap_and_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
